// File: rtl/adc_intf_rx_pkg.sv
// adc_intf_rx_pkg: shared constants and types for the ADC receive interface.
// IQ word layout is {I, Q}, each half IQ_WORD_W/2 bits wide.
package adc_intf_rx_pkg;

    localparam int unsigned IQ_WORD_W           = 32;
    localparam int unsigned ANT0_LSB            = 0;
    localparam int unsigned ANT1_LSB            = 32;
    localparam int unsigned FIFO_DEPTH_LOG2_DEF = 5;

    typedef logic [IQ_WORD_W-1:0]         iq_word_t;
    typedef logic [FIFO_DEPTH_LOG2_DEF:0] fifo_cnt_t;

    // Exchange the I and Q halves of one IQ word.
    function automatic iq_word_t iq_swap_halves(input iq_word_t w);
        return {w[IQ_WORD_W/2-1:0], w[IQ_WORD_W-1:IQ_WORD_W/2]};
    endfunction

endpackage

// File: rtl/adc_intf_rx_rx_iq_fifo_sync.sv
// rx_iq_fifo_sync: single-clock first-word-fall-through FIFO.
// Pointers carry an extra wrap bit so occupancy is a plain subtraction.
// A write while full is accepted only when a read happens in the same cycle.
module rx_iq_fifo_sync #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                do_rd;
    logic                do_wr;

    // Status flags, accept qualification and next pointers.
    always_comb begin
        count_o   = wr_ptr_q - rd_ptr_q;
        empty_o   = (wr_ptr_q == rd_ptr_q);
        full_o    = (count_o == (DEPTH_LOG2+1)'(DEPTH));
        do_rd     = rd_en_i & ~empty_o;
        do_wr     = wr_en_i & (~full_o | do_rd);
        rd_data_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_wr && !flush_i) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/adc_intf_rx.sv
// adc_intf_rx: antenna select, optional decimate-by-2, one stage register,
// then an FWFT FIFO toward the RX accelerator with overflow tracking.
// Optional build macro ADC_INTF_RX_IQ_SWAP_EN adds iq_swap, which stores
// the selected word as {Q,I} instead of {I,Q}.
module adc_intf_rx
    import adc_intf_rx_pkg::*;
#(
    parameter int unsigned IQ_DATA_WIDTH       = 16,
    parameter int unsigned ADC_PACK_DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH_LOG2     = 5,
    parameter int unsigned OVF_CNT_WIDTH       = 16
) (
    input  logic                           acc_clk,
    input  logic                           acc_rstn,
    input  logic [ADC_PACK_DATA_WIDTH-1:0] adc_data,
    input  logic                           adc_valid,
    input  logic                           src_sel,
    input  logic                           ant_flag,
    input  logic                           decim_en,
    output logic [2*IQ_DATA_WIDTH-1:0]     data_to_acc,
    output logic                           data_valid_to_acc,
    input  logic                           acc_ready,
    output logic [FIFO_DEPTH_LOG2:0]       fifo_count,
    output logic                           ovf_sticky,
    output logic [OVF_CNT_WIDTH-1:0]       ovf_cnt,
    input  logic                           ovf_clr
`ifdef ADC_INTF_RX_IQ_SWAP_EN
    ,
    input  logic                           iq_swap
`endif
);

    iq_word_t                 sel_word;
    iq_word_t                 stage_word;
    logic                     keep;
    logic                     phase_q, phase_d;
    logic                     stage_vld_q;
    iq_word_t                 stage_data_q;
    logic                     fifo_full;
    logic                     fifo_empty;
    iq_word_t                 fifo_head;
    fifo_cnt_t                fifo_fill;
    logic                     pop;
    logic                     ovf_evt;
    logic                     ovf_sticky_q, ovf_sticky_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    // Antenna lane select and optional IQ half swap of the incoming sample.
    always_comb begin
        sel_word = ant_flag ? adc_data[ANT1_LSB +: IQ_WORD_W]
                            : adc_data[ANT0_LSB +: IQ_WORD_W];
`ifdef ADC_INTF_RX_IQ_SWAP_EN
        stage_word = iq_swap ? iq_swap_halves(sel_word) : sel_word;
`else
        stage_word = sel_word;
`endif
    end

    // Decimator: keep the sample on phase 0; phase parks at 0 when disabled.
    always_comb begin
        keep    = 1'b0;
        phase_d = phase_q;
        if (src_sel && adc_valid) begin
            if (decim_en) begin
                keep    = ~phase_q;
                phase_d = ~phase_q;
            end else begin
                keep = 1'b1;
            end
        end
        if (!src_sel || !decim_en) phase_d = 1'b0;
    end

    // Stage-1 register; swap choice is captured together with the sample.
    always_ff @(posedge acc_clk or negedge acc_rstn) begin
        if (!acc_rstn) begin
            phase_q      <= 1'b0;
            stage_vld_q  <= 1'b0;
            stage_data_q <= '0;
        end else begin
            phase_q     <= phase_d;
            stage_vld_q <= keep;
            if (keep) stage_data_q <= stage_word;
        end
    end

    rx_iq_fifo_sync #(
        .WIDTH      (IQ_WORD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (acc_clk),
        .rst_ni    (acc_rstn),
        .flush_i   (~src_sel),
        .wr_en_i   (stage_vld_q & src_sel),
        .wr_data_i (stage_data_q),
        .rd_en_i   (pop),
        .rd_data_o (fifo_head),
        .count_o   (fifo_fill),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Output gating and overflow event / counter next-state.
    always_comb begin
        data_valid_to_acc = ~fifo_empty & src_sel;
        data_to_acc       = data_valid_to_acc ? fifo_head : '0;
        fifo_count        = fifo_fill;
        pop               = data_valid_to_acc & acc_ready;
        ovf_evt           = stage_vld_q & src_sel & fifo_full & ~pop;
        ovf_sticky_d      = ovf_sticky_q;
        ovf_cnt_d         = ovf_cnt_q;
        if (ovf_evt) begin
            ovf_sticky_d = 1'b1;
            if (ovf_clr)         ovf_cnt_d = OVF_CNT_WIDTH'(1);
            else if (~&ovf_cnt_q) ovf_cnt_d = ovf_cnt_q + 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
            ovf_cnt_d    = '0;
        end
        ovf_sticky = ovf_sticky_q;
        ovf_cnt    = ovf_cnt_q;
    end

    // Overflow diagnostics registers.
    always_ff @(posedge acc_clk or negedge acc_rstn) begin
        if (!acc_rstn) begin
            ovf_sticky_q <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_intf_rx.sv
// tb_adc_intf_rx: directed scenarios plus random traffic for adc_intf_rx,
// checked every cycle against a queue-based reference model.
module tb_adc_intf_rx;

    logic        acc_clk = 1'b0;
    logic        acc_rstn;
    logic [63:0] adc_data;
    logic        adc_valid;
    logic        src_sel;
    logic        ant_flag;
    logic        decim_en;
    logic [31:0] data_to_acc;
    logic        data_valid_to_acc;
    logic        acc_ready;
    logic [5:0]  fifo_count;
    logic        ovf_sticky;
    logic [15:0] ovf_cnt;
    logic        ovf_clr;
`ifdef ADC_INTF_RX_IQ_SWAP_EN
    logic        iq_swap;
`endif

    always #5 acc_clk = ~acc_clk;

    adc_intf_rx #(
        .IQ_DATA_WIDTH       (16),
        .ADC_PACK_DATA_WIDTH (64),
        .FIFO_DEPTH_LOG2     (5),
        .OVF_CNT_WIDTH       (16)
    ) dut (
        .acc_clk           (acc_clk),
        .acc_rstn          (acc_rstn),
        .adc_data          (adc_data),
        .adc_valid         (adc_valid),
        .src_sel           (src_sel),
        .ant_flag          (ant_flag),
        .decim_en          (decim_en),
        .data_to_acc       (data_to_acc),
        .data_valid_to_acc (data_valid_to_acc),
        .acc_ready         (acc_ready),
        .fifo_count        (fifo_count),
        .ovf_sticky        (ovf_sticky),
        .ovf_cnt           (ovf_cnt),
        .ovf_clr           (ovf_clr)
`ifdef ADC_INTF_RX_IQ_SWAP_EN
        ,
        .iq_swap           (iq_swap)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: what the block holds, in spec terms.
    logic [31:0] m_q[$];      // buffered samples, head first
    bit          m_stg_v;     // a kept sample is waiting one cycle
    logic [31:0] m_stg_d;
    bit          m_phase;     // 1 = next valid sample is discarded
    bit          m_sticky;
    int unsigned m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_stg_v  = 0;
        m_stg_d  = '0;
        m_phase  = 0;
        m_sticky = 0;
        m_cnt    = 0;
    endtask

    task automatic check_outputs();
        bit v;
        v = (m_q.size() != 0) && src_sel;
        check_eq("valid", data_valid_to_acc, v);
        check_eq("data", data_to_acc, v ? m_q[0] : 32'h0);
        check_eq("count", fifo_count, m_q.size());
        check_eq("sticky", ovf_sticky, m_sticky);
        check_eq("ovf_cnt", ovf_cnt, m_cnt);
    endtask

    // Advance the model by one clock using the inputs held during this cycle.
    task automatic model_step();
        bit          v, pop, was_full, evt, keep;
        logic [31:0] w;
        v   = (m_q.size() != 0) && src_sel;
        pop = v && acc_ready;
        if (!src_sel) begin
            m_q.delete();
            m_stg_v = 0;
            m_phase = 0;
            if (ovf_clr) begin
                m_sticky = 0;
                m_cnt    = 0;
            end
        end else begin
            was_full = (m_q.size() == 32);
            evt      = m_stg_v && was_full && !pop;
            if (pop) void'(m_q.pop_front());
            if (m_stg_v && !evt) m_q.push_back(m_stg_d);
            if (evt) begin
                m_sticky = 1;
                m_cnt    = ovf_clr ? 1 : ((m_cnt == 65535) ? m_cnt : m_cnt + 1);
            end else if (ovf_clr) begin
                m_sticky = 0;
                m_cnt    = 0;
            end
            keep = 0;
            if (adc_valid) begin
                if (decim_en) begin
                    keep    = !m_phase;
                    m_phase = !m_phase;
                end else begin
                    keep = 1;
                end
            end
            if (!decim_en) m_phase = 0;
            m_stg_v = keep;
            if (keep) begin
                w = ant_flag ? adc_data[63:32] : adc_data[31:0];
`ifdef ADC_INTF_RX_IQ_SWAP_EN
                if (iq_swap) w = {w[15:0], w[31:16]};
`endif
                m_stg_d = w;
            end
        end
    endtask

    // Check at the falling edge, step the model, land 1 ns after the rising edge.
    task automatic tick();
        @(negedge acc_clk);
        check_outputs();
        model_step();
        @(posedge acc_clk);
        #1;
    endtask

    task automatic idle_inputs();
        adc_data  = '0;
        adc_valid = 0;
        src_sel   = 0;
        ant_flag  = 0;
        decim_en  = 0;
        acc_ready = 0;
        ovf_clr   = 0;
`ifdef ADC_INTF_RX_IQ_SWAP_EN
        iq_swap   = 0;
`endif
    endtask

    initial begin
        idle_inputs();
        acc_rstn = 0;
        model_reset();
        #7;
        check_outputs();
        @(posedge acc_clk);
        #1;
        acc_rstn = 1;
        src_sel  = 1;

        // Single sample, antenna 0 then antenna 1.
        for (int a = 0; a < 2; a++) begin
            acc_ready = 1;
            ant_flag  = a[0];
            adc_data  = 64'hAAAA_BBBB_1111_2222;
            adc_valid = 1;
            tick();
            adc_valid = 0;
            ant_flag  = ~a[0];
            tick();
            #1;
            check_eq("lat_valid", data_valid_to_acc, 1'b1);
            check_eq("lat_data", data_to_acc, (a == 0) ? 32'h1111_2222 : 32'hAAAA_BBBB);
            tick();
            #1;
            check_eq("one_cycle", data_valid_to_acc, 1'b0);
            tick();
        end

        // Decimation: values 0..9 keep 0,2,4,6,8.
        acc_ready = 0;
        decim_en  = 1;
        for (int i = 0; i < 10; i++) begin
            adc_data  = 64'(i);
            adc_valid = 1;
            tick();
        end
        adc_valid = 0;
        tick();
        tick();
        check_eq("decim_peak", fifo_count, 6'd5);
        acc_ready = 1;
        repeat (7) tick();
        decim_en = 0;

        // Overflow: 40 samples into a stalled FIFO.
        acc_ready = 0;
        for (int i = 0; i < 40; i++) begin
            adc_data  = {$urandom, $urandom};
            adc_valid = 1;
            tick();
        end
        adc_valid = 0;
        tick();
        tick();
        check_eq("ovf_full", fifo_count, 6'd32);
        check_eq("ovf_cnt8", ovf_cnt, 16'd8);
        check_eq("ovf_stk", ovf_sticky, 1'b1);
        // Clear coincides with a further drop: the drop wins.
        adc_data  = 64'h1234_5678_9ABC_DEF0;
        adc_valid = 1;
        tick();
        adc_valid = 0;
        ovf_clr   = 1;
        tick();
        ovf_clr = 0;
        check_eq("clr_vs_drop", ovf_cnt, 16'd1);

        // Full FIFO with simultaneous pop and write each cycle.
        adc_data  = 64'h0000_0000_5555_0000;
        adc_valid = 1;
        tick();
        acc_ready = 1;
        for (int i = 1; i <= 20; i++) begin
            adc_data = 64'h0000_0000_5555_0000 + 64'(i);
            tick();
        end
        check_eq("full_pop_cnt", fifo_count, 6'd32);
        check_eq("full_pop_ovf", ovf_cnt, 16'd1);
        adc_valid = 0;
        repeat (36) tick();

        // Flush on src_sel falling.
        acc_ready = 0;
        for (int i = 0; i < 10; i++) begin
            adc_data  = 64'h0000_0000_F100_0000 + 64'(i);
            adc_valid = 1;
            tick();
        end
        adc_valid = 0;
        tick();
        tick();
        check_eq("flush_pre", fifo_count, 6'd10);
        src_sel = 0;
        #1;
        check_eq("flush_gate", data_valid_to_acc, 1'b0);
        tick();
        check_eq("flush_cnt", fifo_count, 6'd0);
        adc_data  = 64'h0000_0000_DEAD_0000;
        adc_valid = 1;
        tick();
        adc_valid = 0;
        src_sel   = 1;
        acc_ready = 1;
        adc_data  = 64'h0000_0000_CAFE_0001;
        adc_valid = 1;
        tick();
        adc_valid = 0;
        tick();
        #1;
        check_eq("reenable_first", data_to_acc, 32'hCAFE_0001);
        repeat (3) tick();

        // Asynchronous reset with 12 entries buffered.
        acc_ready = 0;
        for (int i = 0; i < 12; i++) begin
            adc_data  = {$urandom, $urandom};
            adc_valid = 1;
            tick();
        end
        adc_valid = 0;
        tick();
        tick();
        check_eq("rst_pre", fifo_count, 6'd12);
        #2;
        acc_rstn = 0;
        #1;
        check_eq("rst_valid", data_valid_to_acc, 1'b0);
        check_eq("rst_data", data_to_acc, 32'h0);
        check_eq("rst_count", fifo_count, 6'd0);
        check_eq("rst_stk", ovf_sticky, 1'b0);
        check_eq("rst_ovf", ovf_cnt, 16'd0);
        model_reset();
        @(posedge acc_clk);
        #2;
        acc_rstn  = 1;
        acc_ready = 1;
        adc_data  = 64'hAAAA_BBBB_7777_8888;
        adc_valid = 1;
        tick();
        adc_valid = 0;
        tick();
        #1;
        check_eq("rst_lat", data_to_acc, 32'h7777_8888);
        tick();

        // Random traffic: stalled first half, mostly draining second half.
        for (int i = 0; i < 1600; i++) begin
            adc_data  = {$urandom, $urandom};
            adc_valid = ($urandom_range(0, 2) != 0);
            src_sel   = ($urandom_range(0, 59) != 0);
            ant_flag  = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) decim_en = ~decim_en;
            acc_ready = (i < 800) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 39) == 0);
`ifdef ADC_INTF_RX_IQ_SWAP_EN
            iq_swap   = $urandom_range(0, 1);
`endif
            tick();
        end
        idle_inputs();
        src_sel = 1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
